io_bridge: RTL and testbench

//  Memory-mapped bus bridge downstream of the single-cycle CPU core. Decodes the CPU data-bus

---
 rtl/io_bridge.sv | 139 +++++++++++++
 tb/tb_io_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Memory-mapped bridge between the single-cycle CPU data bus, the data RAM and the board peripherals
// (LEDs, switches, buttons, multiplexed 8-digit 7-segment display, free-running timer).
module io_bridge #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int DRAM_AW      = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        bus_addr,
  input  logic               bus_we,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  output logic [23:0]        led,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [11:0] OFS_DIG = 12'h000;
  localparam logic [11:0] OFS_TMR = 12'h020;
  localparam logic [11:0] OFS_LED = 12'h060;
  localparam logic [11:0] OFS_SW  = 12'h070;
  localparam logic [11:0] OFS_BTN = 12'h078;

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  logic                  in_window;
  logic                  we_dig, we_tmr, we_led;
  logic [31:0]           dig, tmr;
  logic [23:0]           sw_meta, sw_sync;
  logic [4:0]            btn_meta, btn_sync, btn_db;
  logic [4:0][DBW-1:0]   db_cnt;
  logic [SCW-1:0]        scan_cnt;
  logic [2:0]            scan_idx;

  assign in_window  = (bus_addr[31:12] == 20'hFFFFF);
  assign we_dig     = bus_we && in_window && (bus_addr[11:0] == OFS_DIG);
  assign we_tmr     = bus_we && in_window && (bus_addr[11:0] == OFS_TMR);
  assign we_led     = bus_we && in_window && (bus_addr[11:0] == OFS_LED);

  assign dram_addr  = bus_addr[DRAM_AW+1:2];
  assign dram_we    = bus_we && !in_window;
  assign dram_wdata = bus_wdata;

  // Same-cycle read path: the single-cycle core cannot tolerate wait states.
  always_comb begin
    bus_rdata = dram_rdata;
    if (in_window) begin
      case (bus_addr[11:0])
        OFS_DIG: bus_rdata = dig;
        OFS_TMR: bus_rdata = tmr;
        OFS_LED: bus_rdata = {8'h00, led};
        OFS_SW:  bus_rdata = {8'h00, sw_sync};
        OFS_BTN: bus_rdata = {27'h0, btn_db};
        default: bus_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      dig <= '0;
      tmr <= '0;
      led <= '0;
    end else begin
      tmr <= we_tmr ? bus_wdata : tmr + 32'd1;
      if (we_dig) dig <= bus_wdata;
      if (we_led) led <= bus_wdata[23:0];
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // The counter measures how long the synchronised level has disagreed with the accepted level.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      btn_db <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
          btn_db[i] <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  // Glyph follows the live DIG register, so a write shows on the current digit without restarting the scan.
  assign dig_en  = ~(8'b1 << scan_idx);
  assign dig_seg = hex_glyph(dig[{scan_idx, 2'b00} +: 4]);

endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: reset/decode vector table, timer/switch/button/display sequences,
// then randomized traffic compared against a behavioural model of the bridge.
module tb_io_bridge;

  localparam int SD = 4;
  localparam int DB = 16;
  localparam int AW = 14;

  localparam logic [31:0] A_DIG = 32'hFFFFF000;
  localparam logic [31:0] A_TMR = 32'hFFFFF020;
  localparam logic [31:0] A_LED = 32'hFFFFF060;
  localparam logic [31:0] A_SW  = 32'hFFFFF070;
  localparam logic [31:0] A_BTN = 32'hFFFFF078;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata, dram_wdata, dram_rdata;
  logic          bus_we, dram_we;
  logic [AW-1:0] dram_addr;
  logic [23:0]   led, sw;
  logic [4:0]    btn;
  logic [7:0]    dig_en, dig_seg;

  io_bridge #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB), .DRAM_AW(AW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .led(led), .sw(sw), .btn(btn), .dig_en(dig_en), .dig_seg(dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  int errs = 0;
  int checks = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        from_dram;
    logic [31:0] rdata;
    logic        dram_we;
    logic [23:0] led;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Behavioural model: registers as plain values, synchronisers as sample histories,
  // debounce as "the last DB synchronised samples all disagree with the accepted level".
  logic [31:0] m_tmr, m_dig;
  logic [23:0] m_led;
  logic [4:0]  m_db;
  logic [23:0] m_swq[$];
  logic [4:0]  m_btnq[$];
  logic [4:0]  m_win[$];
  int          m_edges;

  task automatic model_reset();
    m_tmr = 0; m_dig = 0; m_led = 0; m_db = 0; m_edges = 0;
    m_swq = '{24'h0, 24'h0};
    m_btnq = '{5'h0, 5'h0};
    m_win = {};
    for (int j = 0; j < DB; j++) m_win.push_back(5'h0);
  endtask

  function automatic logic [31:0] model_read();
    if (bus_addr[31:12] != 20'hFFFFF) return dram_rdata;
    case (bus_addr)
      A_DIG:   return m_dig;
      A_TMR:   return m_tmr;
      A_LED:   return {8'h0, m_led};
      A_SW:    return {8'h0, m_swq[0]};
      A_BTN:   return {27'h0, m_db};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic all_diff;
    m_win.push_back(m_btnq[0]);
    m_win.delete(0);
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      foreach (m_win[j]) if (m_win[j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) m_db[b] = ~m_db[b];
    end
    if (bus_we && bus_addr == A_TMR) m_tmr = bus_wdata;
    else m_tmr = m_tmr + 32'd1;
    if (bus_we && bus_addr == A_DIG) m_dig = bus_wdata;
    if (bus_we && bus_addr == A_LED) m_led = bus_wdata[23:0];
    m_swq.push_back(sw);   m_swq.delete(0);
    m_btnq.push_back(btn); m_btnq.delete(0);
    m_edges++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_en;
    logic [31:0] a;
    int d, n;

    vecs[0]  = '{32'h00000010, 1'b1, 32'h12345678, 1'b1, 32'h0,        1'b1, 24'h000000};
    vecs[1]  = '{A_LED,        1'b1, 32'h00ABCDEF, 1'b0, 32'h0,        1'b0, 24'h000000};
    vecs[2]  = '{A_LED,        1'b0, 32'h0,        1'b0, 32'h00ABCDEF, 1'b0, 24'hABCDEF};
    vecs[3]  = '{32'hFFFFF064, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 24'hABCDEF};
    vecs[4]  = '{A_LED,        1'b1, 32'hFFFFFFFF, 1'b0, 32'h00ABCDEF, 1'b0, 24'hABCDEF};
    vecs[5]  = '{A_LED,        1'b0, 32'h0,        1'b0, 32'h00FFFFFF, 1'b0, 24'hFFFFFF};
    vecs[6]  = '{32'hFFFFF064, 1'b1, 32'h00000055, 1'b0, 32'h0,        1'b0, 24'hFFFFFF};
    vecs[7]  = '{32'hFFFFF064, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 24'hFFFFFF};
    vecs[8]  = '{A_DIG,        1'b1, 32'h76543210, 1'b0, 32'h0,        1'b0, 24'hFFFFFF};
    vecs[9]  = '{A_DIG,        1'b0, 32'h0,        1'b0, 32'h76543210, 1'b0, 24'hFFFFFF};
    vecs[10] = '{32'h00000FFC, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 24'hFFFFFF};
    vecs[11] = '{32'hFFFFE000, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0,        1'b1, 24'hFFFFFF};
    vecs[12] = '{A_SW,         1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0, 24'hFFFFFF};

    cpu_rst = 1'b1; bus_addr = A_TMR; bus_we = 1'b0; bus_wdata = 0;
    dram_rdata = 0; sw = 0; btn = 0;

    // Reset state and timer start
    #3;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'hFE);
    chk("rst_dig_seg", 32'(dig_seg), 32'hC0);
    chk("rst_tmr", bus_rdata, 32'h0);
    step(); step();
    chk("rst_tmr_held", bus_rdata, 32'h0);
    cpu_rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("tmr_after_rst", bus_rdata, 32'(k));
    end

    // Address decode table
    foreach (vecs[i]) begin
      bus_addr = vecs[i].addr; bus_we = vecs[i].we; bus_wdata = vecs[i].wdata;
      dram_rdata = 32'hDEAD0000 | 32'(i);
      #1;
      chk("dec_rdata", bus_rdata, vecs[i].from_dram ? dram_rdata : vecs[i].rdata);
      chk("dec_dram_we", 32'(dram_we), 32'(vecs[i].dram_we));
      chk("dec_dram_addr", 32'(dram_addr), 32'(vecs[i].addr[15:2]));
      chk("dec_dram_wdata", dram_wdata, vecs[i].wdata);
      chk("dec_led", 32'(led), 32'(vecs[i].led));
      step();
    end
    bus_we = 1'b0;

    // Timer wrap through a write
    bus_addr = A_TMR; bus_we = 1'b1; bus_wdata = 32'hFFFFFFFE;
    step();
    bus_we = 1'b0; #1;
    chk("tmr_load", bus_rdata, 32'hFFFFFFFE);
    step(); chk("tmr_inc", bus_rdata, 32'hFFFFFFFF);
    step(); chk("tmr_wrap", bus_rdata, 32'h0);

    // Switch synchroniser latency
    bus_addr = A_SW; sw = 24'h00A5A5; #1;
    chk("sw_lat0", bus_rdata, 32'h0);
    step(); chk("sw_lat1", bus_rdata, 32'h0);
    step(); chk("sw_lat2", bus_rdata, 32'h00A5A5);

    // Button: short pulse rejected, held level accepted after DB+2 edges
    bus_addr = A_BTN; btn = 5'b00001;
    for (int k = 0; k < 2 * DB; k++) begin
      if (k == DB / 2) btn = 5'b0;
      step();
      chk("btn_glitch", bus_rdata, 32'h0);
    end
    btn = 5'b00001; n = 0;
    while (bus_rdata[0] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("btn_hold_latency", 32'(n), 32'(DB + 2));
    chk("btn_hold_value", bus_rdata, 32'h1);
    btn = 5'b0;

    // Mid-operation async reset, then display scan
    bus_addr = A_TMR;
    cpu_rst = 1'b1; #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_tmr", bus_rdata, 32'h0);
    chk("arst_dig_en", 32'(dig_en), 32'hFE);
    cpu_rst = 1'b0;
    bus_addr = A_DIG; bus_we = 1'b1; bus_wdata = 32'h76543210;
    for (int e = 0; e < 9 * SD; e++) begin
      #1;
      d = (e / SD) % 8;
      exp_en = ~(8'b1 << d);
      chk("scan_en", 32'(dig_en), 32'(exp_en));
      chk("scan_seg", 32'(dig_seg), 32'(glyph[d]));
      step();
      bus_we = 1'b0;
    end

    // Randomized traffic against the model
    cpu_rst = 1'b1; #1; cpu_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        cpu_rst = 1'b1; #1;
        chk("rand_arst_led", 32'(led), 32'h0);
        cpu_rst = 1'b0;
        model_reset();
      end
      case ($urandom_range(0, 7))
        0: a = A_DIG;
        1: a = A_TMR;
        2: a = A_LED;
        3: a = A_SW;
        4: a = A_BTN;
        5: a = {20'hFFFFF, 12'($urandom_range(0, 1023) * 4)};
        default: begin
          a = $urandom;
          if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
        end
      endcase
      bus_addr = a; bus_we = 1'($urandom_range(0, 1)); bus_wdata = $urandom;
      dram_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 23) == 0) btn = 5'($urandom);
      #1;
      d = (m_edges / SD) % 8;
      exp_en = ~(8'b1 << d);
      chk("rand_rdata", bus_rdata, model_read());
      chk("rand_dram_we", 32'(dram_we), 32'(bus_we && bus_addr[31:12] != 20'hFFFFF));
      chk("rand_led", 32'(led), 32'(m_led));
      chk("rand_dig_en", 32'(dig_en), 32'(exp_en));
      chk("rand_dig_seg", 32'(dig_seg), 32'(glyph[m_dig[d*4 +: 4]]));
      model_edge();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
